// File: rtl/lcd_bl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : lcd_bl_pkg
// Brief    : Shared constants and types for the LCD backlight controller:
//            register addresses, CTRL bit positions and the fade FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_bl_pkg;

  // Avalon register map
  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_TARGET   = 2'd1;
  localparam logic [1:0] ADDR_STEP_DIV = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  // CTRL register bit positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_FADE_EN  = 1;
  localparam int CTRL_BUSY     = 2;
  localparam int CTRL_IRQ_PEND = 3;
  localparam int CTRL_IRQ_MASK = 4;

  // STATUS write bit that acknowledges the fade-done interrupt
  localparam int STATUS_IRQ_CLR = 8;

  // Fade engine states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } fade_state_e;

endpackage
`default_nettype wire

// File: rtl/lcd_bl_pwm.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bl_pwm
// Brief    : Prescaler, PWM period counter and registered duty comparator.
//            pb pulses for one clk on the tick that wraps the period counter.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_bl_pwm #(
  parameter int PWM_BITS = 8,
  parameter int CLK_DIV  = 195
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic [PWM_BITS-1:0] level,
  output logic                pb,
  output logic                pwm_out
);

  // CLK_DIV = 0 still needs a one-bit prescaler register
  localparam int PRE_W = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
  localparam logic [PRE_W-1:0]    C_PRE_MAX = PRE_W'(CLK_DIV);
  localparam logic [PWM_BITS-1:0] C_LVL_MAX = '1;

  logic [PRE_W-1:0]    r_presc;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                w_tick;

  assign w_tick = en && (r_presc == C_PRE_MAX);
  assign pb     = w_tick && (r_pwm_cnt == C_LVL_MAX);

  // Prescaler: 0..CLK_DIV, parked at 0 while disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (!en || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Period counter: advances per tick, wraps naturally at all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
    end else if (!en) begin
      r_pwm_cnt <= '0;
    end else if (w_tick) begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  // Registered comparator; all-ones level forces a solid high output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= en && ((r_pwm_cnt < level) || (level == C_LVL_MAX));
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_backlight_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_backlight_ctrl
// Brief    : Avalon-MM backlight dimmer. Register file plus a fade engine that
//            moves the PWM level toward TARGET, changing it only at PWM period
//            boundaries so every period has a clean duty cycle.
//            Optional macro LCD_BL_IRQ_EN adds the fade-done interrupt
//            (irq_pend, irq_mask); without it irq is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_backlight_ctrl #(
  parameter int PWM_BITS = 8,
  parameter int CLK_DIV  = 195,
  parameter int STEP_W   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        irq
);
  import lcd_bl_pkg::*;

  logic                r_en;
  logic                r_fade_en;
  logic [PWM_BITS-1:0] r_target;
  logic [STEP_W-1:0]   r_step_div;
  logic [PWM_BITS-1:0] r_level;
  logic [STEP_W-1:0]   r_step_cnt;
  fade_state_e         r_state;

  logic                w_wr;
  logic                w_pb;
  logic                w_busy;
  logic                w_up;
  logic [PWM_BITS-1:0] w_level_step;
  logic [PWM_BITS-1:0] w_level_nxt;
  logic [STEP_W-1:0]   w_step_cnt_nxt;
  fade_state_e         w_state_nxt;
  logic                w_done;
  logic                w_irq_pend;
  logic                w_irq_mask;
  logic                w_unused_ok;

  assign w_wr         = chipselect && !write_n;
  assign w_busy       = (r_level != r_target);
  assign w_up         = (r_target > r_level);
  // Only used when busy, so it never wraps past 0 or all-ones
  assign w_level_step = w_up ? (r_level + 1'b1) : (r_level - 1'b1);
  assign w_unused_ok  = &{1'b0, writedata, w_done};

  lcd_bl_pwm #(
    .PWM_BITS (PWM_BITS),
    .CLK_DIV  (CLK_DIV)
  ) u_pwm (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (r_en),
    .level   (r_level),
    .pb      (w_pb),
    .pwm_out (out_port)
  );

  // Fade engine next state; direction is re-derived from target vs level at every pb
  always_comb begin
    w_level_nxt    = r_level;
    w_state_nxt    = r_state;
    w_step_cnt_nxt = r_step_cnt;
    w_done         = 1'b0;
    if (w_pb) begin
      if (!r_fade_en) begin
        w_level_nxt    = r_target;
        w_state_nxt    = IDLE;
        w_step_cnt_nxt = '0;
        w_done         = w_busy;
      end else if (!w_busy) begin
        w_state_nxt    = IDLE;
        w_step_cnt_nxt = '0;
        w_done         = (r_state != IDLE);
      end else begin
        w_state_nxt = w_up ? UP : DOWN;
        // >= tolerates STEP_DIV being lowered below the running count
        if (r_step_cnt >= r_step_div) begin
          w_step_cnt_nxt = '0;
          w_level_nxt    = w_level_step;
          if (w_level_step == r_target) begin
            w_state_nxt = IDLE;
            w_done      = 1'b1;
          end
        end else begin
          w_step_cnt_nxt = r_step_cnt + 1'b1;
        end
      end
    end
  end

  // Register file writes and fade state; pb never fires while disabled, freezing the fade
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en       <= 1'b0;
      r_fade_en  <= 1'b0;
      r_target   <= '0;
      r_step_div <= '0;
      r_level    <= '0;
      r_step_cnt <= '0;
      r_state    <= IDLE;
    end else begin
      r_level    <= w_level_nxt;
      r_step_cnt <= w_step_cnt_nxt;
      r_state    <= w_state_nxt;
      if (w_wr) begin
        case (address)
          ADDR_CTRL: begin
            r_en      <= writedata[CTRL_EN];
            r_fade_en <= writedata[CTRL_FADE_EN];
          end
          ADDR_TARGET:   r_target   <= writedata[PWM_BITS-1:0];
          ADDR_STEP_DIV: r_step_div <= writedata[STEP_W-1:0];
          default: ;
        endcase
      end
    end
  end

`ifdef LCD_BL_IRQ_EN
  logic r_irq_pend;
  logic r_irq_mask;

  // Fade-done latch; a completion in the same cycle as an acknowledge wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_pend <= 1'b0;
      r_irq_mask <= 1'b0;
    end else begin
      if (w_wr && (address == ADDR_CTRL)) begin
        r_irq_mask <= writedata[CTRL_IRQ_MASK];
      end
      if (w_done) begin
        r_irq_pend <= 1'b1;
      end else if (w_wr && (address == ADDR_STATUS) && writedata[STATUS_IRQ_CLR]) begin
        r_irq_pend <= 1'b0;
      end
    end
  end

  assign w_irq_pend = r_irq_pend;
  assign w_irq_mask = r_irq_mask;
  assign irq        = r_irq_pend && r_irq_mask;
`else
  assign w_irq_pend = 1'b0;
  assign w_irq_mask = 1'b0;
  assign irq        = 1'b0;
`endif

  // Zero-wait-state read mux, unused bits read as 0
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_EN]       = r_en;
        readdata[CTRL_FADE_EN]  = r_fade_en;
        readdata[CTRL_BUSY]     = w_busy;
        readdata[CTRL_IRQ_PEND] = w_irq_pend;
        readdata[CTRL_IRQ_MASK] = w_irq_mask;
      end
      ADDR_TARGET:   readdata[PWM_BITS-1:0] = r_target;
      ADDR_STEP_DIV: readdata[STEP_W-1:0]   = r_step_div;
      default:       readdata[PWM_BITS-1:0] = r_level;
    endcase
  end

endmodule
`default_nettype wire
